// File: rtl/lsu_seq_if.sv
// Request/response bundle between a core and lsu_seq.
// The core side uses master; the LSU uses slave.
interface lsu_seq_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_fault;

  modport master (
    output i_req_valid, i_addr, i_wdata, i_we, i_funct3,
    input  o_req_ready, o_rsp_valid, o_rdata,
    input  o_misaligned, o_fault
  );

  modport slave (
    input  i_req_valid, i_addr, i_wdata, i_we, i_funct3,
    output o_req_ready, o_rsp_valid, o_rdata,
    output o_misaligned, o_fault
  );
endinterface

// File: rtl/lsu_seq.sv
// Sequential load/store unit: one request at a time, byte-split misaligned.
// LSU_MISALIGN_SPLIT_EN enables splitting; otherwise misaligned requests fault.
module lsu_seq #(
  parameter int SIZE = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  lsu_seq_if.slave    bus,
  output logic [15:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_control,
  input  logic [31:0] i_dmem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  beat;
  logic [31:0] asm_q;

  logic [1:0]  sz;
  logic        mis;
  logic        bad;
  logic        oor;
  logic        split;
  logic        fault;
  logic [16:0] last;
  logic [1:0]  nlast;
  logic [31:0] asm_nx;
  logic [31:0] ext;

  assign sz = f3_q[1:0];
  assign bus.o_req_ready = (state == IDLE);
  assign nlast = (sz == 2'b01) ? 2'd1 : 2'd3;

  // Classify the latched request: alignment, legality, range.
  always_comb begin
    mis  = 1'b1;
    last = {1'b0, a_q};
    unique case (sz)
      2'b00: mis = 1'b0;
      2'b01: begin
        mis  = a_q[0];
        last = {1'b0, a_q} + 17'd1;
      end
      2'b10: begin
        mis  = |a_q[1:0];
        last = {1'b0, a_q} + 17'd3;
      end
      2'b11: begin
        mis  = 1'b1;
        last = {1'b0, a_q} + 17'd3;
      end
    endcase
    bad = (f3_q == 3'b011) | (f3_q[2:1] == 2'b11)
        | (we_q & f3_q[2]);
    oor = (last >= 17'(SIZE));
`ifdef LSU_MISALIGN_SPLIT_EN
    split = mis & ~bad & ~oor;
    fault = bad | oor;
`else
    split = 1'b0;
    fault = bad | oor | mis;
`endif
  end

  // Drive the memory port only while an access beat is in flight.
  always_comb begin
    o_lsu_addr = '0;
    o_st_data  = '0;
    o_lsu_wren = 1'b0;
    o_control  = '0;
    if (state == ACCESS) begin
      if (split) begin
        o_lsu_addr = a_q + {14'd0, beat};
        o_control  = we_q ? 3'b000 : 3'b100;
        o_st_data  = {24'd0, wd_q[{beat, 3'b000} +: 8]};
        o_lsu_wren = we_q & ~i_rst;
      end else begin
        o_lsu_addr = a_q;
        o_control  = f3_q;
        o_st_data  = wd_q;
        o_lsu_wren = we_q & ~fault & ~i_rst;
      end
    end
  end

  // Assembly value after this beat, and its extended form.
  always_comb begin
    asm_nx = asm_q;
    if (split) begin
      asm_nx[{beat, 3'b000} +: 8] = i_dmem_data[7:0];
    end else begin
      asm_nx = i_dmem_data;
    end
    unique case (f3_q)
      3'b000:  ext = {{24{asm_nx[7]}}, asm_nx[7:0]};
      3'b001:  ext = {{16{asm_nx[15]}}, asm_nx[15:0]};
      3'b100:  ext = {24'd0, asm_nx[7:0]};
      3'b101:  ext = {16'd0, asm_nx[15:0]};
      default: ext = asm_nx;
    endcase
  end

  // Request sequencer with registered response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      beat             <= '0;
      asm_q            <= '0;
      bus.o_rsp_valid  <= 1'b0;
      bus.o_rdata      <= '0;
      bus.o_misaligned <= 1'b0;
      bus.o_fault      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            a_q   <= bus.i_addr;
            wd_q  <= bus.i_wdata;
            we_q  <= bus.i_we;
            f3_q  <= bus.i_funct3;
            beat  <= '0;
            asm_q <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          asm_q <= asm_nx;
          if (split && (beat != nlast)) begin
            beat <= beat + 2'd1;
          end else begin
            state            <= RESP;
            bus.o_rsp_valid  <= 1'b1;
            bus.o_rdata      <= (we_q | fault) ? '0 : ext;
            bus.o_misaligned <= mis;
            bus.o_fault      <= fault;
          end
        end
        RESP: begin
          bus.o_rsp_valid <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: directed cases plus random traffic
// against a byte-array reference memory.
module tb_lsu_seq;
  localparam int SIZE = 1024;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  lat;
    logic [31:0] rd;
    logic        mis;
    logic        flt;
    logic [7:0]  wrs;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic        o_lsu_wren;
  logic [2:0]  o_control;
  logic [31:0] i_dmem_data;

  lsu_seq_if bus();

  lsu_seq #(.SIZE(SIZE)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .o_lsu_addr  (o_lsu_addr),
    .o_st_data   (o_st_data),
    .o_lsu_wren  (o_lsu_wren),
    .o_control   (o_control),
    .i_dmem_data (i_dmem_data)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] mem     [SIZE];
  logic [7:0] ref_mem [SIZE];
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;

  // Combinational memory read, little-endian word at o_lsu_addr.
  always_comb begin
    int j;
    i_dmem_data = '0;
    for (int k = 0; k < 4; k++) begin
      j = int'(o_lsu_addr) + k;
      if (j < SIZE) i_dmem_data[8*k +: 8] = mem[j[9:0]];
    end
  end

  // Memory write: sample the port late in the cycle, commit on the edge.
  initial begin
    logic        pw;
    logic [15:0] pa;
    logic [31:0] pd;
    logic [2:0]  pc;
    int nb, j;
    forever begin
      @(negedge i_clk);
      #3;
      pw = o_lsu_wren; pa = o_lsu_addr;
      pd = o_st_data;  pc = o_control;
      @(posedge i_clk);
      if (pw) begin
        wr_cnt++;
        nb = (pc[1:0] == 2'b00) ? 1 : (pc[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
          j = int'(pa) + k;
          if (j < SIZE) mem[j[9:0]] = pd[8*k +: 8];
        end
      end
    end
  end

  function automatic void poke(input int a, input logic [7:0] v);
    mem[a[9:0]] = v;
    ref_mem[a[9:0]] = v;
  endfunction

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < SIZE; i++)
      if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // Reference: RV32I load/store semantics on a byte array.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [15:0] a, input logic [31:0] wd);
    exp_t e;
    int w, j;
    logic ill, al, oor, flt;
    logic [31:0] v;
    w   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    al  = (f3[1:0] == 2'b00) || (f3[1:0] == 2'b01 && a[0] == 1'b0)
       || (f3[1:0] == 2'b10 && a[1:0] == 2'b00);
    oor = (int'(a) + w - 1) >= SIZE;
    flt = ill || oor || (!al && !SPLIT);
    e.mis = !al;
    e.flt = flt;
    e.lat = (flt || al) ? 8'd2 : (w == 2) ? 8'd3 : 8'd5;
    e.rd  = '0;
    e.wrs = '0;
    if (!flt && we) begin
      for (int i = 0; i < w; i++) begin
        j = int'(a) + i;
        ref_mem[j[9:0]] = wd[8*i +: 8];
      end
      e.wrs = al ? 8'd1 : 8'(w);
    end else if (!flt) begin
      v = '0;
      for (int i = 0; i < w; i++) begin
        j = int'(a) + i;
        v[8*i +: 8] = ref_mem[j[9:0]];
      end
      case (f3)
        3'd0:    e.rd = {{24{v[7]}}, v[7:0]};
        3'd1:    e.rd = {{16{v[15]}}, v[15:0]};
        3'd4:    e.rd = {24'd0, v[7:0]};
        3'd5:    e.rd = {16'd0, v[15:0]};
        default: e.rd = v;
      endcase
    end
    return e;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [15:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic mis, output logic flt,
                        output int wrs, output logic pls);
    int w0;
    lat = 0; rd = '0; mis = 1'b0; flt = 1'b0; pls = 1'b0;
    @(negedge i_clk);
    for (int i = 0; i < 20 && !bus.o_req_ready; i++) @(negedge i_clk);
    bus.i_req_valid = 1'b1;
    bus.i_we = we; bus.i_funct3 = f3;
    bus.i_addr = a; bus.i_wdata = wd;
    w0 = wr_cnt;
    @(posedge i_clk);
    #1 bus.i_req_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (bus.o_rsp_valid) begin
        lat = n + 1;
        rd = bus.o_rdata; mis = bus.o_misaligned; flt = bus.o_fault;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge i_clk);
      @(negedge i_clk);
      pls = !bus.o_rsp_valid && bus.o_req_ready;
    end
    wrs = wr_cnt - w0;
  endtask

  int l, wc;
  logic [31:0] r;
  logic m, f, p;

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    n_vec++;
    if (bus.o_req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_ready got=%b exp=1", bus.o_req_ready);
    end
    n_vec++;
    if (bus.o_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.o_rsp_valid);
    end
    n_vec++;
    if ({bus.o_rdata, bus.o_misaligned, bus.o_fault} !== 34'd0) begin
      n_err++; $display("FAIL rst_outputs got=%h/%b/%b exp=0/0/0",
                        bus.o_rdata, bus.o_misaligned, bus.o_fault);
    end
    n_vec++;
    if ({o_lsu_addr, o_st_data, o_lsu_wren, o_control} !== 52'd0) begin
      n_err++; $display("FAIL rst_mem_port got=%h/%h/%b/%b exp=0",
                        o_lsu_addr, o_st_data, o_lsu_wren, o_control);
    end
  endtask

  task automatic test_aligned();
    void'(model(1'b1, 3'd2, 16'h0100, 32'hDEADBEEF));
    do_req(1'b1, 3'd2, 16'h0100, 32'hDEADBEEF, l, r, m, f, wc, p);
    n_vec++;
    if (l !== 2 || f !== 1'b0 || wc !== 1 || p !== 1'b1) begin
      n_err++; $display("FAIL sw_aligned lat=%0d flt=%b wr=%0d pulse=%b exp=2/0/1/1",
                        l, f, wc, p);
    end
    n_vec++;
    if ({mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL sw_bytes got=%h %h %h %h exp=EF BE AD DE",
                        mem[16'h100], mem[16'h101], mem[16'h102], mem[16'h103]);
    end
    void'(model(1'b0, 3'd2, 16'h0100, 32'h0));
    do_req(1'b0, 3'd2, 16'h0100, 32'h0, l, r, m, f, wc, p);
    n_vec++;
    if (l !== 2 || r !== 32'hDEADBEEF || m !== 1'b0 || f !== 1'b0) begin
      n_err++; $display("FAIL lw_aligned lat=%0d rd=%h mis=%b flt=%b exp=2/DEADBEEF/0/0",
                        l, r, m, f);
    end
    n_vec++;
    if ({o_lsu_addr, o_st_data, o_lsu_wren, o_control} !== 52'd0) begin
      n_err++; $display("FAIL idle_mem_port got=%h/%h/%b/%b exp=0",
                        o_lsu_addr, o_st_data, o_lsu_wren, o_control);
    end
  endtask

  task automatic test_misaligned();
    poke(16'h101, 8'h11); poke(16'h102, 8'h22);
    poke(16'h103, 8'h33); poke(16'h104, 8'h44);
    void'(model(1'b0, 3'd2, 16'h0101, 32'h0));
    do_req(1'b0, 3'd2, 16'h0101, 32'h0, l, r, m, f, wc, p);
    n_vec++;
    if (SPLIT && (l !== 5 || r !== 32'h44332211 || m !== 1'b1 || f !== 1'b0)) begin
      n_err++; $display("FAIL lw_split lat=%0d rd=%h mis=%b flt=%b exp=5/44332211/1/0",
                        l, r, m, f);
    end else if (!SPLIT && (l !== 2 || r !== 32'h0 || m !== 1'b1 || f !== 1'b1)) begin
      n_err++; $display("FAIL lw_nosplit lat=%0d rd=%h mis=%b flt=%b exp=2/0/1/1",
                        l, r, m, f);
    end
    poke(16'h003, 8'h80); poke(16'h004, 8'hFF);
    void'(model(1'b0, 3'd1, 16'h0003, 32'h0));
    do_req(1'b0, 3'd1, 16'h0003, 32'h0, l, r, m, f, wc, p);
    n_vec++;
    if (SPLIT && (l !== 3 || r !== 32'hFFFFFF80 || m !== 1'b1 || p !== 1'b1)) begin
      n_err++; $display("FAIL lh_split lat=%0d rd=%h mis=%b exp=3/FFFFFF80/1", l, r, m);
    end else if (!SPLIT && (l !== 2 || f !== 1'b1 || r !== 32'h0)) begin
      n_err++; $display("FAIL lh_nosplit lat=%0d rd=%h flt=%b exp=2/0/1", l, r, f);
    end
    void'(model(1'b0, 3'd5, 16'h0003, 32'h0));
    do_req(1'b0, 3'd5, 16'h0003, 32'h0, l, r, m, f, wc, p);
    n_vec++;
    if (r !== (SPLIT ? 32'h0000FF80 : 32'h0)) begin
      n_err++; $display("FAIL lhu_mis rd=%h exp=%h", r, SPLIT ? 32'h0000FF80 : 32'h0);
    end
    void'(model(1'b1, 3'd2, 16'h0102, 32'hCAFEF00D));
    do_req(1'b1, 3'd2, 16'h0102, 32'hCAFEF00D, l, r, m, f, wc, p);
    n_vec++;
    if (wc !== (SPLIT ? 4 : 0) || l !== (SPLIT ? 5 : 2) || r !== 32'h0) begin
      n_err++; $display("FAIL sw_mis wr=%0d lat=%0d rd=%h exp=%0d/%0d/0",
                        wc, l, r, SPLIT ? 4 : 0, SPLIT ? 5 : 2);
    end
    n_vec++;
    if (mem_diffs() != 0) begin
      n_err++; $display("FAIL mis_mem diffs=%0d exp=0", mem_diffs());
    end
  endtask

  task automatic test_fault();
    poke(16'h3FE, 8'h5A); poke(16'h3FF, 8'hA5);
    void'(model(1'b1, 3'd2, 16'h03FE, 32'h12345678));
    do_req(1'b1, 3'd2, 16'h03FE, 32'h12345678, l, r, m, f, wc, p);
    n_vec++;
    if (l !== 2 || f !== 1'b1 || wc !== 0 || m !== 1'b1) begin
      n_err++; $display("FAIL sw_oor lat=%0d flt=%b wr=%0d mis=%b exp=2/1/0/1",
                        l, f, wc, m);
    end
    n_vec++;
    if ({mem[16'h3FF], mem[16'h3FE]} !== 16'hA55A) begin
      n_err++; $display("FAIL oor_bytes got=%h%h exp=A55A", mem[16'h3FF], mem[16'h3FE]);
    end
    void'(model(1'b0, 3'd4, 16'h03FF, 32'h0));
    do_req(1'b0, 3'd4, 16'h03FF, 32'h0, l, r, m, f, wc, p);
    n_vec++;
    if (l !== 2 || f !== 1'b0 || r !== 32'h000000A5) begin
      n_err++; $display("FAIL lbu_top lat=%0d flt=%b rd=%h exp=2/0/000000A5", l, f, r);
    end
    void'(model(1'b1, 3'd4, 16'h0010, 32'hFFFFFFFF));
    do_req(1'b1, 3'd4, 16'h0010, 32'hFFFFFFFF, l, r, m, f, wc, p);
    n_vec++;
    if (l !== 2 || f !== 1'b1 || wc !== 0 || r !== 32'h0) begin
      n_err++; $display("FAIL st_illegal lat=%0d flt=%b wr=%0d rd=%h exp=2/1/0/0",
                        l, f, wc, r);
    end
    void'(model(1'b0, 3'd3, 16'h0100, 32'h0));
    do_req(1'b0, 3'd3, 16'h0100, 32'h0, l, r, m, f, wc, p);
    n_vec++;
    if (l !== 2 || f !== 1'b1 || r !== 32'h0) begin
      n_err++; $display("FAIL ld_illegal lat=%0d flt=%b rd=%h exp=2/1/0", l, f, r);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic we;
    logic [2:0] f3;
    logic [15:0] a;
    logic [31:0] wd;
    for (int it = 0; it < 120; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 2)
        a = 16'(SIZE - 4 + $urandom_range(0, 5));
      else
        a = 16'($urandom_range(0, SIZE - 1));
      wd = $urandom;
      e = model(we, f3, a, wd);
      do_req(we, f3, a, wd, l, r, m, f, wc, p);
      n_vec++;
      if (l !== int'(e.lat)) begin
        n_err++; $display("FAIL rnd_lat it=%0d got=%0d exp=%0d", it, l, e.lat);
      end
      n_vec++;
      if (r !== e.rd) begin
        n_err++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, r, e.rd);
      end
      n_vec++;
      if ({m, f} !== {e.mis, e.flt}) begin
        n_err++; $display("FAIL rnd_flags it=%0d got=%b%b exp=%b%b", it, m, f, e.mis, e.flt);
      end
      n_vec++;
      if (wc !== int'(e.wrs)) begin
        n_err++; $display("FAIL rnd_writes it=%0d got=%0d exp=%0d", it, wc, e.wrs);
      end
      n_vec++;
      if (p !== 1'b1) begin
        n_err++; $display("FAIL rnd_pulse it=%0d got=%b exp=1", it, p);
      end
      if (it % 10 == 9) begin
        n_vec++;
        if (mem_diffs() != 0) begin
          n_err++; $display("FAIL rnd_mem it=%0d diffs=%0d exp=0", it, mem_diffs());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    for (int i = 16'h201; i <= 16'h204; i++) poke(i, 8'h00);
    @(negedge i_clk);
    bus.i_req_valid = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = 3'd2;
    bus.i_addr = 16'h0201; bus.i_wdata = 32'hA1B2C3D4;
    @(posedge i_clk);
    #1 bus.i_req_valid = 1'b0;
    repeat (SPLIT ? 2 : 0) begin
      @(negedge i_clk);
      seen |= bus.o_rsp_valid;
      @(posedge i_clk);
    end
    @(negedge i_clk);
    seen |= bus.o_rsp_valid;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    n_vec++;
    if (bus.o_req_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_ready got=%b exp=1", bus.o_req_ready);
    end
    repeat (6) begin
      @(negedge i_clk);
      seen |= bus.o_rsp_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL midrst_rsp got=%b exp=0", seen);
    end
    if (SPLIT) begin
      ref_mem[10'h201] = 8'hD4;
      ref_mem[10'h202] = 8'hC3;
    end
    n_vec++;
    if ({mem[16'h204], mem[16'h203], mem[16'h202], mem[16'h201]} !==
        {16'h0000, ref_mem[10'h202], ref_mem[10'h201]}) begin
      n_err++; $display("FAIL midrst_bytes got=%h %h %h %h exp=%h %h 00 00",
                        mem[16'h201], mem[16'h202], mem[16'h203], mem[16'h204],
                        ref_mem[10'h201], ref_mem[10'h202]);
    end
    void'(model(1'b0, 3'd4, 16'h0201, 32'h0));
    do_req(1'b0, 3'd4, 16'h0201, 32'h0, l, r, m, f, wc, p);
    n_vec++;
    if (l !== 2 || r !== {24'd0, ref_mem[10'h201]}) begin
      n_err++; $display("FAIL post_rst_lbu lat=%0d rd=%h exp=2/%h",
                        l, r, {24'd0, ref_mem[10'h201]});
    end
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_we = 1'b0; bus.i_funct3 = '0;
    i_rst = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_aligned();
    test_misaligned();
    test_fault();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/lsu_seq.md
LSU_SEQ -- requirements
Module: lsu_seq

Interface
REQ-001 The block SHALL have parameter SIZE, default 1024, giving the data-memory size in bytes, valid range 1..65536.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the request-side ports:
- i_req_valid, input, 1: request present.
- o_req_ready, output, 1: request accepted this cycle.
- i_addr, input, 16: byte address.
- i_wdata, input, 32: store data.
- i_we, input, 1: 1 = store, 0 = load.
- i_funct3, input, 3: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-005 The block SHALL have the response-side ports:
- o_rsp_valid, output, 1: one-cycle completion pulse.
- o_rdata, output, 32: extended load result.
- o_misaligned, output, 1: request was misaligned.
- o_fault, output, 1: request was out-of-range or illegal.
REQ-006 The block SHALL have the memory-side ports:
- o_lsu_addr, output, 16.
- o_st_data, output, 32.
- o_lsu_wren, output, 1.
- o_control, output, 3.
- i_dmem_data, input, 32.
- Memory-side behaviour: the memory reads combinationally and writes on the clock edge.

Function
REQ-007 The block SHALL implement FSM states IDLE, ACCESS and RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-008 On the acceptance cycle T (i_req_valid & o_req_ready), the block SHALL latch addr, wdata, we and funct3, clear the beat counter and the assembly register, and go to ACCESS.
REQ-009 A request SHALL be aligned when it is a byte access, a halfword access with addr[0]=0, or a word access with addr[1:0]=0.
REQ-010 An aligned request SHALL take one ACCESS beat driving the latched addr, funct3 and wdata (wren = we); a load SHALL capture i_dmem_data at the end of that beat.
REQ-011 A misaligned request SHALL take N beats (N=2 for halfword, N=4 for word); beat k SHALL drive addr+k.
- Load beats: control 100; i_dmem_data[7:0] is captured into assembly byte k.
- Store beats: control 000, with wdata byte k on o_st_data[7:0].
REQ-012 After the last beat the block SHALL enter RESP and assert o_rsp_valid for exactly one cycle, then return to IDLE.
- Aligned requests: response at T+2.
- Misaligned halfword: response at T+3.
- Misaligned word: response at T+5.
REQ-013 The load o_rdata SHALL be the assembled value extended per funct3 (sign-extend for 000/001, zero-extend for 100/101); for stores o_rdata SHALL be 0.
REQ-014 If addr + width - 1 >= SIZE, the request SHALL:
- complete with o_fault=1 and o_rdata=0;
- hold o_lsu_wren at 0 for all its beats;
- keep the same latency as an aligned request.
REQ-015 Illegal funct3 (011, 110, 111, or a store with funct3[2]=1) SHALL respond at T+2 with o_fault=1, o_rdata=0 and no write.
REQ-016 Outside ACCESS, the memory-side outputs SHALL be 0 (o_lsu_wren=0).
REQ-017 o_rdata, o_misaligned and o_fault SHALL be registered and held stable while o_rsp_valid=1.
REQ-018 o_misaligned SHALL reflect REQ-009 for every completed request, including faulted requests.

Reset
REQ-019 When i_rst=1 at a clock edge, the block SHALL set the state to IDLE and clear the beat counter, assembly register, o_rsp_valid, o_rdata, o_misaligned and o_fault.
REQ-020 During and after reset, o_req_ready SHALL be 1 from the first cycle with i_rst=0.
REQ-021 Reset in the middle of a split SHALL abort the request with no response; bytes already written remain written.

Configuration
REQ-022 When macro LSU_MISALIGN_SPLIT_EN is defined, misaligned requests SHALL be split as in REQ-011.
REQ-023 When LSU_MISALIGN_SPLIT_EN is undefined, misaligned requests SHALL:
- take one beat with o_lsu_wren=0;
- respond at T+2 with o_misaligned=1, o_fault=1 and o_rdata=0.
- Aligned behaviour is identical in both builds.

Verification
REQ-024 Aligned access: SW addr 0x0100, data 0xDEADBEEF, then LW 0x0100 -> memory bytes 0x100..0x103 = EF BE AD DE; LW response at T+2 with o_rdata=0xDEADBEEF and o_misaligned=0.
REQ-025 Misaligned word load (split build): bytes 0x101..0x104 = 11 22 33 44, then LW 0x0101 -> four byte beats at 0x101..0x104; response at T+5 with o_rdata=0x44332211 and o_misaligned=1.
REQ-026 Misaligned halfword load: bytes 0x003 = 0x80, 0x004 = 0xFF; LH 0x0003 -> o_rdata=0xFFFFFF80 at T+3; LHU 0x0003 -> o_rdata=0x0000FF80.
REQ-027 Out-of-range store: SIZE=1024, SW 0x03FE -> o_fault=1 at T+2, o_lsu_wren never asserted, bytes 0x3FE..0x3FF unchanged.
REQ-028 Reset during a split: misaligned SW 0x0201 with 0xA1B2C3D4, i_rst=1 during beat 2 -> no o_rsp_valid; 0x201 = D4 and 0x202 = C3 written; 0x203 and 0x204 unchanged; o_req_ready=1 after reset.
REQ-029 Non-split build: LW 0x0101 -> at T+2 o_misaligned=1, o_fault=1, o_rdata=0, and no memory write.
